// File: rtl/fp32_pkg.sv
// Shared single-precision constants and state encoding for the FP add, multiply
// and divide execution units.
package fp32_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_UNPACK = 6'b000010;
  localparam logic [5:0] ST_ALIGN  = 6'b000100;
  localparam logic [5:0] ST_ADD    = 6'b001000;
  localparam logic [5:0] ST_NORM   = 6'b010000;
  localparam logic [5:0] ST_ROUND  = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE   = ST_IDLE,
    S_UNPACK = ST_UNPACK,
    S_ALIGN  = ST_ALIGN,
    S_ADD    = ST_ADD,
    S_NORM   = ST_NORM,
    S_ROUND  = ST_ROUND
  } state_t;

  // Arguments are the magnitude bits only; the sign never matters here.
  function automatic logic is_nan(input logic [EXP_W+FRAC_W-1:0] v);
    return (&v[EXP_W+FRAC_W-1:FRAC_W]) && (|v[FRAC_W-1:0]);
  endfunction

  function automatic logic is_inf(input logic [EXP_W+FRAC_W-1:0] v);
    return (&v[EXP_W+FRAC_W-1:FRAC_W]) && !(|v[FRAC_W-1:0]);
  endfunction

endpackage

// File: rtl/fp32_add_sub_if.sv
// Request/response bundle between the ALU controller plus path and the FP adder.
interface fp32_add_sub_if;
  import fp32_pkg::*;

  logic                    start;
  logic                    op;
  logic [EXP_W+FRAC_W:0]   data1_in;
  logic [EXP_W+FRAC_W:0]   data2_in;
  logic [EXP_W+FRAC_W:0]   result_out;
  logic                    vld_out;
  logic                    busy;

  modport master (
    output start, op, data1_in, data2_in,
    input  result_out, vld_out, busy
  );

  modport slave (
    input  start, op, data1_in, data2_in,
    output result_out, vld_out, busy
  );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int W     = 28,
  parameter int CNT_W = 5
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt
);
  always_comb begin
    cnt = CNT_W'(W);
    // Ascending scan so the highest set bit is the last to write cnt.
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CNT_W'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp32_add_sub.sv
// Single-precision add/subtract unit: fixed five-cycle FSM datapath,
// round-to-nearest-even, denormals flushed to zero on input and output.
module fp32_add_sub #(
  parameter int          EXP_W  = fp32_pkg::EXP_W,
  parameter int          FRAC_W = fp32_pkg::FRAC_W,
  parameter logic [31:0] QNAN   = fp32_pkg::QNAN
) (
  input logic           sys_clk,
  input logic           sys_rst,
  fp32_add_sub_if.slave bus
);
  import fp32_pkg::*;

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int ALN_W  = SIG_W + 3;
  localparam int SUM_W  = ALN_W + 1;
  localparam int IEXP_W = EXP_W + 2;
  localparam int LZC_W  = $clog2(SUM_W + 1);
  localparam logic signed [IEXP_W-1:0] EXP_MAX = IEXP_W'(2 * BIAS + 1);
  localparam logic [EXP_W-1:0]         ALN_LIM = EXP_W'(ALN_W);

  state_t state, state_nxt;

  logic [W-1:0]               a_p0, b_p0;
  logic                       sign_l_p1, sign_s_p1;
  logic signed [IEXP_W-1:0]   exp_l_p1;
  logic [EXP_W-1:0]           diff_p1;
  logic [SIG_W-1:0]           sig_l_p1, sig_s_p1;
  logic                       spec_p1;
  logic [W-1:0]               spec_val_p1;
  logic [ALN_W-1:0]           aln_l_p2, aln_s_p2;
  logic [SUM_W-1:0]           sum_p3;
  logic [ALN_W-1:0]           nrm_p4;
  logic signed [IEXP_W-1:0]   exp_n_p4;
  logic                       zero_p4;

  logic [EXP_W-1:0]           ea, eb;
  logic [SIG_W-1:0]           ma, mb;
  logic                       a_ge, a_nan, b_nan, a_inf, b_inf, spec;
  logic [W-1:0]               spec_val;
  logic [ALN_W-1:0]           aln_field, aln_mask, aln_shift;
  logic                       aln_sticky;
  logic [SUM_W-1:0]           sum_c;
  logic [LZC_W-1:0]           lzc_cnt;
  logic [SUM_W-1:0]           nrm_shl;
  logic [ALN_W-1:0]           nrm_c;
  logic signed [IEXP_W-1:0]   exp_n_c;
  logic [SIG_W:0]             rnd;
  logic signed [IEXP_W-1:0]   exp_r;
  logic [FRAC_W-1:0]          frac_r;
  logic [W-1:0]               res_rnd;

  function automatic logic [SIG_W:0] round_rne(input logic [ALN_W-1:0] m);
    logic inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[ALN_W-1:3]} + {{SIG_W{1'b0}}, inc};
  endfunction

  function automatic logic [W-1:0] pack_sat(input logic s,
                                            input logic signed [IEXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
    if (e >= EXP_MAX)                     pack_sat = s ? NEG_INF : POS_INF;
    else if (e <= $signed(IEXP_W'(0)))    pack_sat = {s, {(W-1){1'b0}}};
    else                                  pack_sat = {s, e[EXP_W-1:0], f};
  endfunction

  assign bus.busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = S_ALIGN;
      S_ALIGN:  state_nxt = S_ADD;
      S_ADD:    state_nxt = S_NORM;
      S_NORM:   state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= S_IDLE;
      bus.vld_out    <= 1'b0;
      bus.result_out <= '0;
    end else begin
      state       <= state_nxt;
      bus.vld_out <= (state == S_ROUND);
      if (state == S_ROUND) bus.result_out <= res_rnd;
    end
  end

  // Unpack: flush denormals, order operands by magnitude, resolve specials.
  always_comb begin
    ea    = a_p0[W-2:FRAC_W];
    eb    = b_p0[W-2:FRAC_W];
    ma    = (ea == '0) ? '0 : {1'b1, a_p0[FRAC_W-1:0]};
    mb    = (eb == '0) ? '0 : {1'b1, b_p0[FRAC_W-1:0]};
    a_ge  = {ea, ma} >= {eb, mb};
    a_nan = is_nan(a_p0[W-2:0]);
    b_nan = is_nan(b_p0[W-2:0]);
    a_inf = is_inf(a_p0[W-2:0]);
    b_inf = is_inf(b_p0[W-2:0]);
    spec  = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_p0[W-1] != b_p0[W-1])))
      spec_val = QNAN;
    else if (a_inf)
      spec_val = a_p0[W-1] ? NEG_INF : POS_INF;
    else
      spec_val = b_p0[W-1] ? NEG_INF : POS_INF;
  end

  // Align: smaller significand shifted right, shifted-out bits folded into sticky.
  always_comb begin
    aln_field  = {sig_s_p1, 3'b000};
    aln_mask   = '0;
    aln_shift  = '0;
    aln_sticky = 1'b0;
    if (diff_p1 >= ALN_LIM) begin
      aln_sticky = |sig_s_p1;
    end else begin
      aln_mask   = (ALN_W'(1) << diff_p1) - ALN_W'(1);
      aln_shift  = aln_field >> diff_p1;
      aln_sticky = |(aln_field & aln_mask);
    end
  end

  // Add: magnitude ordering guarantees the subtraction never goes negative.
  always_comb begin
    if (sign_l_p1 ^ sign_s_p1) sum_c = {1'b0, aln_l_p2} - {1'b0, aln_s_p2};
    else                       sum_c = {1'b0, aln_l_p2} + {1'b0, aln_s_p2};
  end

  fp_lzc #(.W(SUM_W), .CNT_W(LZC_W)) u_lzc (
    .din (sum_p3),
    .cnt (lzc_cnt)
  );

  // Normalise: hidden bit lands on bit ALN_W-1; lzc counts from the carry bit.
  always_comb begin
    nrm_shl = sum_p3 << (lzc_cnt - LZC_W'(1));
    if (sum_p3[SUM_W-1]) begin
      nrm_c   = {sum_p3[SUM_W-1:2], sum_p3[1] | sum_p3[0]};
      exp_n_c = exp_l_p1 + $signed(IEXP_W'(1));
    end else begin
      nrm_c   = nrm_shl[ALN_W-1:0];
      exp_n_c = exp_l_p1 + $signed(IEXP_W'(1)) - $signed(IEXP_W'(lzc_cnt));
    end
  end

  // Round and pack; exact zeros are negative only when both operands were.
  always_comb begin
    rnd    = round_rne(nrm_p4);
    exp_r  = rnd[SIG_W] ? exp_n_p4 + $signed(IEXP_W'(1)) : exp_n_p4;
    frac_r = rnd[SIG_W] ? rnd[SIG_W-1:1] : rnd[FRAC_W-1:0];
    if (spec_p1)      res_rnd = spec_val_p1;
    else if (zero_p4) res_rnd = {sign_l_p1 & sign_s_p1, {(W-1){1'b0}}};
    else              res_rnd = pack_sat(sign_l_p1, exp_r, frac_r);
  end

  always_ff @(posedge sys_clk) begin
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          a_p0 <= bus.data1_in;
          b_p0 <= {bus.data2_in[W-1] ^ bus.op, bus.data2_in[W-2:0]};
        end
      end
      S_UNPACK: begin
        sign_l_p1   <= a_ge ? a_p0[W-1] : b_p0[W-1];
        sign_s_p1   <= a_ge ? b_p0[W-1] : a_p0[W-1];
        exp_l_p1    <= $signed({2'b00, (a_ge ? ea : eb)});
        diff_p1     <= a_ge ? (ea - eb) : (eb - ea);
        sig_l_p1    <= a_ge ? ma : mb;
        sig_s_p1    <= a_ge ? mb : ma;
        spec_p1     <= spec;
        spec_val_p1 <= spec_val;
      end
      S_ALIGN: begin
        aln_l_p2 <= {sig_l_p1, 3'b000};
        aln_s_p2 <= aln_shift | {{(ALN_W-1){1'b0}}, aln_sticky};
      end
      S_ADD: begin
        sum_p3 <= sum_c;
      end
      S_NORM: begin
        nrm_p4   <= nrm_c;
        exp_n_p4 <= exp_n_c;
        zero_p4  <= (sum_p3 == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp32_add_sub.sv
// Randomised scoreboard bench for fp32_add_sub against an exact-arithmetic
// reference that rounds once from the true sum.
module tb_fp32_add_sub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    int          t;
  } exp_t;

  logic sys_clk;
  logic sys_rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  fp32_add_sub_if bus ();

  fp32_add_sub dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d results outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Exact sum on a fixed-point grid with lsb 2^-149, then a single RNE rounding.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b_in,
                                          input logic op);
    logic [31:0]  b;
    logic         sa, sb, rs;
    int           ea, eb, p, e, sh;
    logic [299:0] va, vb, mag, rem, half, mant;
    b     = b_in;
    b[31] = b_in[31] ^ op;
    sa = a[31];
    sb = b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC0_0000;
    if (ea == 255) return {sa, 8'hFF, 23'h0};
    if (eb == 255) return {sb, 8'hFF, 23'h0};
    va = (ea == 0) ? '0 : (300'({1'b1, a[22:0]}) << (ea - 1));
    vb = (eb == 0) ? '0 : (300'({1'b1, b[22:0]}) << (eb - 1));
    if (sa == sb)      begin mag = va + vb; rs = sa; end
    else if (va >= vb) begin mag = va - vb; rs = sa; end
    else               begin mag = vb - va; rs = sb; end
    if (mag == 0) return {sa & sb, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((300'(1) << sh) - 300'(1));
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 300'(1);
      if (mant[24]) begin
        mant = mant >> 1;
        e++;
      end
    end
    if (e >= 255) return rs ? 32'hFF80_0000 : 32'h7F80_0000;
    if (e <= 0)   return {rs, 31'h0};
    return {rs, 8'(e), mant[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Caller is at posedge+1; the next edge samples start.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] r);
    exp_t e;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.data1_in = a;
    bus.data2_in = b;
    e.a   = a;
    e.b   = b;
    e.op  = op;
    e.res = r;
    e.t   = cyc + 6;
    exp_q.push_back(e);
    @(posedge sys_clk); #1;
    bus.start    = 1'b0;
    bus.data1_in = $urandom;
    bus.data2_in = $urandom;
    bus.op       = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (bus.vld_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_vld: got result %h at cycle %0d, expected no valid", bus.result_out, cyc);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.result_out !== e.res) begin
          n_fail++;
          $display("FAIL result a=%h b=%h op=%0d: got %h, expected %h", e.a, e.b, e.op, bus.result_out, e.res);
        end
        n_chk++;
        if (cyc != e.t) begin
          n_fail++;
          $display("FAIL latency a=%h b=%h: got vld at cycle %0d, expected %0d", e.a, e.b, cyc, e.t);
        end
      end
    end
  end

  logic [96:0] dir [16];

  initial begin
    logic [31:0] a, b, r;
    logic        op;
    dir = '{
      {32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000},
      {32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000},
      {32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000},
      {32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000},
      {32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002},
      {32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000},
      {32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000},
      {32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000},
      {32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000},
      {32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000},
      {32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000},
      {32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000},
      {32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000},
      {32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000},
      {32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000},
      {32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000}
    };

    sys_rst      = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 1'b0;
    bus.data1_in = '0;
    bus.data2_in = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_result", bus.result_out, 32'h0);
    check("reset_vld", 32'(bus.vld_out), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 16; i++) begin
      a  = dir[i][96:65];
      b  = dir[i][64:33];
      op = dir[i][32];
      r  = dir[i][31:0];
      check($sformatf("ref_model_%0d", i), ref_add(a, b, op), r);
      issue(a, b, op, r);
      wait_drain($sformatf("directed_%0d", i));
    end

    // A second start while busy must be ignored.
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    @(posedge sys_clk); #1;
    check("busy_in_flight", 32'(bus.busy), 32'h1);
    bus.start    = 1'b1;
    bus.data1_in = 32'h4120_0000;
    bus.data2_in = 32'h4120_0000;
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    wait_drain("busy_start");
    repeat (8) @(posedge sys_clk);
    #1;

    // Reset in S_ADD aborts: no valid, result cleared.
    issue(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    exp_q.delete();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check("abort_result", bus.result_out, 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    repeat (8) @(posedge sys_clk);
    #1;
    check("abort_result_hold", bus.result_out, 32'h0);
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    wait_drain("after_abort");

    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        1: begin
          a[30:23] = 8'($urandom_range(90, 160));
          b[30:23] = 8'(int'(a[30:23]) + $urandom_range(0, 30) - 15);
        end
        2: begin
          b     = a ^ 32'($urandom_range(0, 255));
          b[31] = 1'($urandom_range(0, 1));
          op    = ~(a[31] ^ b[31]);
        end
        3: begin
          a[30:23] = 8'($urandom_range(0, 4));
          b[30:23] = 8'($urandom_range(0, 4));
        end
        4: begin
          a[30:23] = 8'($urandom_range(250, 255));
          b[30:23] = 8'($urandom_range(250, 255));
          if ($urandom_range(0, 1) == 1) a[22:0] = '0;
        end
        default: ;
      endcase
      issue(a, b, op, ref_add(a, b, op));
      wait_drain("random");
    end

    repeat (8) @(posedge sys_clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
